// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared state encoding and default width for the sequential
//                restoring divider.
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    // Divisor / quotient / remainder width; the dividend is twice this.
    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/HexDriver.sv
`default_nettype none
// ============================================================================
//  Module      : HexDriver
//  Description : Nibble to active-low seven-segment pattern (gfedcba).
//  Revision    : 1.0  initial release
// ============================================================================
module HexDriver (
    input  logic [3:0] In0,
    output logic [6:0] Out0
);

    // Pure lookup, segments are lit by driving them low.
    always_comb begin
        Out0 = 7'b1111111;
        case (In0)
            4'h0: Out0 = 7'b1000000;
            4'h1: Out0 = 7'b1111001;
            4'h2: Out0 = 7'b0100100;
            4'h3: Out0 = 7'b0110000;
            4'h4: Out0 = 7'b0011001;
            4'h5: Out0 = 7'b0010010;
            4'h6: Out0 = 7'b0000010;
            4'h7: Out0 = 7'b1111000;
            4'h8: Out0 = 7'b0000000;
            4'h9: Out0 = 7'b0010000;
            4'hA: Out0 = 7'b0001000;
            4'hB: Out0 = 7'b0000011;
            4'hC: Out0 = 7'b1000110;
            4'hD: Out0 = 7'b0100001;
            4'hE: Out0 = 7'b0000110;
            4'hF: Out0 = 7'b0001110;
            default: Out0 = 7'b1111111;
        endcase
    end

endmodule : HexDriver
`default_nettype wire

// File: rtl/divider_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : divider_fsm
//  Description : Control for the restoring divider: state register, Run edge
//                detection, iteration counter and datapath strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module divider_fsm
    import div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_run,
    input  logic i_overflow,   // datapath: upper dividend half >= divisor
    output logic o_load,       // start cycle: capture operands
    output logic o_check,      // CHECK state
    output logic o_iter,       // ITER state
    output logic o_last,       // final ITER cycle, results get written
    output logic o_busy,
    output logic o_done
);

    localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    div_state_t      r_state;
    div_state_t      w_next;
    logic            r_run_prev;
    logic [c_CW-1:0] r_count;
    logic            w_start;
    logic            w_last;

    // Only a rising edge of Run while idle or finished starts an operation.
    assign w_start = i_run && !r_run_prev && ((r_state == IDLE) || (r_state == DONE));
    assign w_last  = (r_state == ITER) && (r_count == c_LAST);

    // State, edge-detect history and iteration counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_run_prev <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_next;
            r_run_prev <= i_run;
            if (w_start) begin
                r_count <= '0;
            end else if (r_state == ITER) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Next-state selection and control strobes.
    always_comb begin
        w_next  = r_state;
        o_load  = 1'b0;
        o_check = 1'b0;
        o_iter  = 1'b0;
        o_last  = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = CHECK;
                    o_load = 1'b1;
                end
            end
            CHECK: begin
                o_check = 1'b1;
                o_busy  = 1'b1;
                w_next  = i_overflow ? DONE : ITER;
            end
            ITER: begin
                o_iter = 1'b1;
                o_busy = 1'b1;
                o_last = w_last;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                if (w_start) begin
                    w_next = CHECK;
                    o_load = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule : divider_fsm
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
//  Module      : divider
//  Description : Sequential restoring divider, 2*WIDTH-bit dividend by
//                WIDTH-bit divisor, results in WIDTH+2 cycles, shown on four
//                seven-segment displays.
//  Revision    : 1.0  initial release
// ============================================================================
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic [2*WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0]   Divisor,
    output logic [WIDTH-1:0]   Quotient,
    output logic [WIDTH-1:0]   Remainder,
    output logic               Busy,
    output logic               Done,
    output logic               Overflow,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3
);

    logic             w_load;
    logic             w_check;
    logic             w_iter;
    logic             w_last;
    logic             w_ovf;

    // Partial remainder carries one extra bit so the shifted value never wraps.
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_overflow;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_div_ext;
    logic [WIDTH:0]   w_rem_diff;
    logic             w_fits;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    logic [7:0]       w_quo8;
    logic [7:0]       w_rem8;

    divider_fsm #(
        .WIDTH (WIDTH)
    ) u_fsm (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_run      (Run),
        .i_overflow (w_ovf),
        .o_load     (w_load),
        .o_check    (w_check),
        .o_iter     (w_iter),
        .o_last     (w_last),
        .o_busy     (Busy),
        .o_done     (Done)
    );

    // At CHECK r_rem still holds the upper dividend half; D == 0 lands here too.
    assign w_div_ext = {1'b0, r_div};
    assign w_ovf     = (r_rem >= w_div_ext);

    // One restoring step: shift {R,Q} left, subtract D when it fits.
    always_comb begin
        w_rem_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_rem_diff  = w_rem_shift - w_div_ext;
        w_fits      = (w_rem_shift >= w_div_ext);
        w_rem_next  = w_fits ? w_rem_diff : w_rem_shift;
        w_quo_next  = {r_quo[WIDTH-2:0], w_fits};
    end

    // Working registers and visible result registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_load) begin
                r_rem      <= {1'b0, Dividend[2*WIDTH-1:WIDTH]};
                r_quo      <= Dividend[WIDTH-1:0];
                r_div      <= Divisor;
                r_overflow <= 1'b0;
            end
            if (w_check && w_ovf) begin
                r_quotient  <= '1;
                r_remainder <= '0;
                r_overflow  <= 1'b1;
            end
            if (w_iter) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                if (w_last) begin
                    r_quotient  <= w_quo_next;
                    r_remainder <= w_rem_next[WIDTH-1:0];
                end
            end
        end
    end

    assign Quotient  = r_quotient;
    assign Remainder = r_remainder;
    assign Overflow  = r_overflow;

    // Displays show the low byte of each result regardless of WIDTH.
    assign w_quo8 = 8'(r_quotient);
    assign w_rem8 = 8'(r_remainder);

    HexDriver u_hex0 (.In0(w_rem8[3:0]), .Out0(HEX0));
    HexDriver u_hex1 (.In0(w_rem8[7:4]), .Out0(HEX1));
    HexDriver u_hex2 (.In0(w_quo8[3:0]), .Out0(HEX2));
    HexDriver u_hex3 (.In0(w_quo8[7:4]), .Out0(HEX3));

endmodule : divider
`default_nettype wire

// File: doc/divider.md
# divider

Sequential restoring divider that is the inverse companion of the lab's Booth multiplier. It divides a 2·WIDTH-bit unsigned dividend (normally the multiplier's 16-bit product bus) by a WIDTH-bit unsigned divisor taken from the synchronized switches. It produces a WIDTH-bit quotient and remainder in WIDTH+2 cycles and shows the results on four seven-segment displays. It is a top-level lab block driven by the board clock and push-buttons.

## Interface
- WIDTH, 8, divisor/quotient/remainder width; dividend is 2·WIDTH.
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high; returns the block to IDLE and clears every output register.
- Run  in  1  level start request; only a 0→1 transition (internally edge-detected) starts an operation.
- Dividend  in  2·WIDTH  unsigned dividend N; sampled on the start cycle only.
- Divisor  in  WIDTH  unsigned divisor D; sampled on the start cycle only.
- Quotient  out  WIDTH  registered result.
- Remainder  out  WIDTH  registered result.
- Busy  out  1  high from the cycle after start through the last iteration.
- Done  out  1  high in DONE state; held until the next start or Reset.
- Overflow  out  1  quotient not representable or D==0; valid while Done is high.
- HEX0..HEX3  out  7 each  Remainder[3:0], Remainder[7:4], Quotient[3:0], Quotient[7:4] (low 8 bits only).

## Operation
- States are IDLE, CHECK, ITER and DONE.
- Start condition: Run==1, Run_prev==0, and state is IDLE or DONE. The block latches N and D, loads R ← {0, N[2W-1:W]} (W+1 bits) and Q ← N[W-1:0], clears the iteration counter, sets Done=0 and Overflow=0, then goes to CHECK.
- Run edges in CHECK or ITER are ignored. Run held high does not retrigger.
- CHECK: if N[2W-1:W] ≥ D (this covers D==0), the block sets Quotient=all-ones, Remainder=0 and Overflow=1, then goes to DONE. Otherwise it goes to ITER.
- ITER, repeated exactly WIDTH cycles:
  - {R,Q} ← {R,Q} << 1.
  - If the shifted R ≥ {0,D}, then R ← R − D and Q[0] ← 1. Otherwise Q[0] ← 0.
  - The compare and subtract are on W+1 bits.
  - The counter goes 0..WIDTH−1. When it reaches WIDTH−1 the block goes to DONE and writes Quotient=Q and Remainder=R[W−1:0].
- DONE: Done=1 and Busy=0. Results hold. A start condition begins a new operation; results hold their old values until the new result is written.
- Reset in any state, including mid-ITER: the next cycle has state IDLE, Quotient=Remainder=0, Busy=Done=Overflow=0 and Run_prev=0.
- Reset and a Run edge in the same cycle: Reset wins and no operation starts.

## Timing
- Cycle 0 is the start cycle (edge detected).
- Cycle 1: CHECK, Busy=1.
- Cycles 2..W+1: ITER.
- Cycle W+2: DONE, with Done=1 and the outputs valid. For WIDTH=8 this is cycle 10.
- Overflow path: DONE at cycle 2.
- Busy=1 exactly in cycles 1..W+1, or only cycle 1 on overflow.
- HEX outputs are combinational from the registered Quotient and Remainder.
- Reset values: every output is 0. HEX shows "0" patterns.

## Structure
- Package div_pkg holds the state enum (IDLE, CHECK, ITER, DONE) and the default WIDTH constant.
- Sub-module divider_fsm holds the state register, Run edge detect, iteration counter and the Busy/Done/load/shift controls.
- The datapath (R, Q, subtractor) stays in divider.
- The existing HexDriver is instantiated four times.

## Test plan
- N=0x0064, D=0x07, Run pulse → at cycle 10: Quotient=0x0E, Remainder=0x02, Overflow=0, Done=1. Busy=1 during cycles 1–9.
- N=0x3EC1, D=0x3F → Quotient=0xFF, Remainder=0x00, Overflow=0.
- N=0x0010, D=0x00 → at cycle 2: Overflow=1, Quotient=0xFF, Remainder=0x00, Done=1.
- N=0x1234, D=0x12 → Overflow=1 at cycle 2. Then with Run held high, no restart and Done stays 1.
- Start N=0x0064/D=0x07. Toggle Run 0→1 again at cycle 4 → ignored, result unchanged. Change Dividend to 0xFFFF at cycle 3 → result still 0x0E/0x02.
- Assert Reset at cycle 5 of an operation → cycle 6: Busy=0, Done=0, Quotient=Remainder=0. A following Run edge yields a correct fresh result.
